fetch_redirect_unit: RTL and testbench

//  IF-stage responder to the ID-stage hazard unit and the EX/MEM branch outcome. Owns PC and IF/ID register.

---
 rtl/fetch_redirect_unit_pkg.sv | 15 +
 rtl/fetch_pc_select.sv | 42 ++++
 rtl/fetch_redirect_unit.sv | 101 ++++++++++
 tb/tb_fetch_redirect_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared constants for the IF-stage fetch/redirect block.
// Also holds the jump-target formation helper used by the PC selector.
package fetch_redirect_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

  // J-type target: upper nibble of the delay PC, 26-bit word index, word aligned.
  function automatic logic [WORD_W-1:0] jump_target(input logic [3:0] region,
                                                    input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_select.sv
// Next-PC priority mux: taken branch > jump in ID > hazard hold > sequential.
// Also reports which redirect (if any) fires this cycle.
module fetch_pc_select
  import fetch_redirect_unit_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              ifid_valid,
  input  logic              id_jump,
  input  logic              exmem_eqbranch,
  input  logic              exmem_neqbranch,
  input  logic              exmem_zero,
  input  logic [WORD_W-1:0] exmem_br_target,
  input  logic [3:0]        jump_region,
  input  logic [25:0]       jump_index,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] next_pc,
  output logic              br_taken,
  output logic              jmp
);

  logic [WORD_W-1:0] jtgt;

  assign pc_plus4 = pc + PC_STEP;
  assign jtgt     = jump_target(jump_region, jump_index);
  assign br_taken = (exmem_eqbranch & exmem_zero) | (exmem_neqbranch & ~exmem_zero);
  // A jump held in ID by a stall waits until IF/ID is allowed to advance.
  assign jmp      = id_jump & ifid_valid & ifid_write;

  always_comb begin
    next_pc = pc_plus4;
    if (br_taken) begin
      next_pc = exmem_br_target;
    end else if (jmp) begin
      next_pc = jtgt;
    end else if (!pc_write) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF stage: owns PC and the IF/ID register, applies hazard stalls and redirects,
// drives flush strobes downstream and keeps saturating stall/flush counters.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              pc_write,
  input  logic              ifid_write,
  input  logic              id_jump,
  input  logic              exmem_eqbranch,
  input  logic              exmem_neqbranch,
  input  logic              exmem_zero,
  input  logic [31:0]       exmem_br_target,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc_plus4,
  output logic              ifid_valid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        br_taken;
  logic        jmp;
  logic        redirect;
  logic        stall_event;

  fetch_pc_select u_pc_select (
    .pc              (pc),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_valid      (ifid_valid),
    .id_jump         (id_jump),
    .exmem_eqbranch  (exmem_eqbranch),
    .exmem_neqbranch (exmem_neqbranch),
    .exmem_zero      (exmem_zero),
    .exmem_br_target (exmem_br_target),
    .jump_region     (ifid_pc_plus4[31:28]),
    .jump_index      (ifid_instr[25:0]),
    .pc_plus4        (pc_plus4),
    .next_pc         (next_pc),
    .br_taken        (br_taken),
    .jmp             (jmp)
  );

  assign imem_addr   = pc;
  assign redirect    = br_taken | jmp;
  // Only stalls that actually hold the PC count; a redirect overrides the stall.
  assign stall_event = ~pc_write & ~redirect;

  // Jumps resolve in ID, so only a taken branch reaches back into ID/EX and EX/MEM.
  assign flush_idex  = br_taken;
  assign flush_exmem = br_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      pc <= next_pc;
      if (redirect) begin
        ifid_instr    <= '0;
        ifid_pc_plus4 <= '0;
        ifid_valid    <= 1'b0;
      end else if (ifid_write) begin
        ifid_instr    <= imem_instr;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_event && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (redirect && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: the stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_fetch_redirect_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        pc_write;
  logic        ifid_write;
  logic        id_jump;
  logic        exmem_eqbranch;
  logic        exmem_neqbranch;
  logic        exmem_zero;
  logic [31:0] exmem_br_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        flush_idex;
  logic        flush_exmem;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  fetch_redirect_unit dut (
    .clock           (clock),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .id_jump         (id_jump),
    .exmem_eqbranch  (exmem_eqbranch),
    .exmem_neqbranch (exmem_neqbranch),
    .exmem_zero      (exmem_zero),
    .exmem_br_target (exmem_br_target),
    .ifid_instr      (ifid_instr),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .flush_idex      (flush_idex),
    .flush_exmem     (flush_exmem),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        fidex;
    logic        fexmem;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  localparam logic [31:0] J_100 = 32'h0800_0040;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pp4, input logic valid,
                              input logic fidex, input logic fexmem,
                              input logic [15:0] scnt, input logic [15:0] fcnt);
    exp_t e;
    e.addr = addr; e.instr = instr; e.pp4 = pp4; e.valid = valid;
    e.fidex = fidex; e.fexmem = fexmem; e.scnt = scnt; e.fcnt = fcnt;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, "imem_addr",     imem_addr,              e.addr);
      chk(n, "ifid_instr",    ifid_instr,             e.instr);
      chk(n, "ifid_pc_plus4", ifid_pc_plus4,          e.pp4);
      chk(n, "ifid_valid",    {31'd0, ifid_valid},    {31'd0, e.valid});
      chk(n, "flush_idex",    {31'd0, flush_idex},    {31'd0, e.fidex});
      chk(n, "flush_exmem",   {31'd0, flush_exmem},   {31'd0, e.fexmem});
      chk(n, "stall_cnt",     {16'd0, stall_cnt},     {16'd0, e.scnt});
      chk(n, "flush_cnt",     {16'd0, flush_cnt},     {16'd0, e.fcnt});
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue what the
  // outputs must look like before the next rising edge.
  task automatic cycle(input string nm, input logic rst, input logic pw, input logic iw,
                       input logic jp, input logic eq, input logic neq, input logic z,
                       input logic [31:0] tgt, input logic [31:0] ins, input exp_t e);
    reset = rst; pc_write = pw; ifid_write = iw; id_jump = jp;
    exmem_eqbranch = eq; exmem_neqbranch = neq; exmem_zero = z;
    exmem_br_target = tgt; imem_instr = ins;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; id_jump = 1'b0;
    exmem_eqbranch = 1'b0; exmem_neqbranch = 1'b0; exmem_zero = 1'b0;
    exmem_br_target = 32'd0; imem_instr = 32'd0;
    repeat (2) @(posedge clock);
    #1;

    // sequential fetch after reset
    cycle("seq0", 0,1,1,0,0,0,0, 32'd0, instr_at(32'h0), mk(32'h0, 32'h0, 32'h0, 0,0,0, 16'd0, 16'd0));
    cycle("seq1", 0,1,1,0,0,0,0, 32'd0, instr_at(32'h4), mk(32'h4, instr_at(32'h0), 32'h4, 1,0,0, 16'd0, 16'd0));
    cycle("seq2", 0,1,1,0,0,0,0, 32'd0, instr_at(32'h8), mk(32'h8, instr_at(32'h4), 32'h8, 1,0,0, 16'd0, 16'd0));
    cycle("seq3", 0,1,1,0,0,0,0, 32'd0, instr_at(32'hC), mk(32'hC, instr_at(32'h8), 32'hC, 1,0,0, 16'd0, 16'd0));
    // one-cycle stall at 0x10
    cycle("stall", 0,0,0,0,0,0,0, 32'd0, instr_at(32'h10), mk(32'h10, instr_at(32'hC), 32'h10, 1,0,0, 16'd0, 16'd0));
    cycle("held",  0,1,1,0,0,0,0, 32'd0, instr_at(32'h10), mk(32'h10, instr_at(32'hC), 32'h10, 1,0,0, 16'd1, 16'd0));
    cycle("fetchj", 0,1,1,0,0,0,0, 32'd0, J_100, mk(32'h14, instr_at(32'h10), 32'h14, 1,0,0, 16'd1, 16'd0));
    // jump in ID while stalled is not taken
    cycle("jstall", 0,0,0,1,0,0,0, 32'd0, instr_at(32'h18), mk(32'h18, J_100, 32'h18, 1,0,0, 16'd1, 16'd0));
    cycle("jump",   0,1,1,1,0,0,0, 32'd0, instr_at(32'h18), mk(32'h18, J_100, 32'h18, 1,0,0, 16'd2, 16'd0));
    // bubble in ID: id_jump must be ignored
    cycle("jtgt",   0,1,1,1,0,0,0, 32'd0, instr_at(32'h100), mk(32'h100, 32'h0, 32'h0, 0,0,0, 16'd2, 16'd1));
    // taken BEQ with concurrent stall and active jump: branch wins
    cycle("beq",    0,0,1,1,1,0,1, 32'h200, instr_at(32'h104), mk(32'h104, instr_at(32'h100), 32'h104, 1,1,1, 16'd2, 16'd1));
    cycle("bne_nt", 0,1,1,0,0,1,1, 32'h300, instr_at(32'h200), mk(32'h200, 32'h0, 32'h0, 0,0,0, 16'd2, 16'd2));
    cycle("bne_t",  0,1,1,0,0,1,0, 32'hFFFF_FFFC, instr_at(32'h204), mk(32'h204, instr_at(32'h200), 32'h204, 1,1,1, 16'd2, 16'd2));
    cycle("top",    0,1,1,0,0,0,0, 32'd0, instr_at(32'hFFFF_FFFC), mk(32'hFFFF_FFFC, 32'h0, 32'h0, 0,0,0, 16'd2, 16'd3));
    cycle("wrap",   0,1,1,0,1,0,0, 32'h400, instr_at(32'h0), mk(32'h0, instr_at(32'hFFFF_FFFC), 32'h0, 1,0,0, 16'd2, 16'd3));

    // long stall drives stall_cnt past its ceiling
    pc_write = 1'b0; ifid_write = 1'b0; exmem_eqbranch = 1'b0;
    repeat (65541) @(posedge clock);
    #1;
    cycle("sat",    0,0,0,0,0,0,0, 32'd0, instr_at(32'h4), mk(32'h4, instr_at(32'h0), 32'h4, 1,0,0, 16'hFFFF, 16'd3));
    // reset during a stall with a taken branch pending
    cycle("rst_in", 1,0,0,0,1,0,1, 32'h800, instr_at(32'h4), mk(32'h4, instr_at(32'h0), 32'h4, 1,1,1, 16'hFFFF, 16'd3));
    cycle("rst_out",0,1,1,0,0,0,0, 32'd0, instr_at(32'h0), mk(32'h0, 32'h0, 32'h0, 0,0,0, 16'd0, 16'd0));

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
